// File: rtl/vpu_pkg.sv
// ============================================================================
// Module : vpu_pkg
// Brief  : Shared types, header field offsets and helpers for the VPU packer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int HDR_MASK_LSB = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // The count field sits directly above the P-bit lane mask.
    function automatic int hdr_cnt_lsb(input int p);
        return HDR_MASK_LSB + p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/zc_compact.sv
// ============================================================================
// Module : zc_compact
// Brief  : Combinational zero-compaction: packs masked-in lanes in lane order.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module zc_compact
    import vpu_pkg::*;
#(
    parameter int P  = 64,
    parameter int CW = clog2(P + 1)
) (
    input  logic [P*8-1:0] lane_data,
    input  logic [P-1:0]   lane_mask,
    output logic [P*8-1:0] packed_data,
    output logic [CW-1:0]  nnz
);

    logic [CW-1:0] w_pos [P];
    logic [CW-1:0] w_acc;

    // w_pos[i] is the output byte slot lane i lands in when it is masked in.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < P; i++) begin
            w_pos[i] = w_acc;
            w_acc    = w_acc + CW'(lane_mask[i]);
        end
        nnz = w_acc;
    end

    always_comb begin
        packed_data = '0;
        for (int k = 0; k < P; k++) begin
            for (int i = k; i < P; i++) begin
                if (lane_mask[i] && (w_pos[i] == CW'(k))) begin
                    packed_data[8*k +: 8] = packed_data[8*k +: 8] | lane_data[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vpu_zc_packer.sv
// ============================================================================
// Module : vpu_zc_packer
// Brief  : Emits one header beat plus ceil(nnz/B) zero-compressed data beats.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vpu_zc_packer
    import vpu_pkg::*;
#(
    parameter int P  = 64,
    parameter int B  = 16,
    parameter int CW = clog2(P + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [P*8-1:0] in_data,
    input  logic [P-1:0]   in_nonz,
    input  logic           in_dense,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [B*8-1:0] out_data,
    output logic           out_hdr,
    output logic           out_last
);

    localparam int c_BW      = B * 8;
    localparam int c_NBEAT   = P / B;
    localparam int c_NBW     = clog2(c_NBEAT + 1);
    localparam int c_CNT_LSB = hdr_cnt_lsb(P);

    state_t           r_state;
    logic [P*8-1:0]   r_packed;
    logic [c_NBW-1:0] r_nbeats;
    logic [c_NBW-1:0] r_beat_cnt;
    logic             r_out_valid;
    logic             r_out_hdr;
    logic             r_out_last;
    logic [c_BW-1:0]  r_out_data;
    logic             r_in_ready;

    logic [P-1:0]     w_mask;
    logic [P*8-1:0]   w_packed;
    logic [CW-1:0]    w_nnz;
    logic [c_NBW-1:0] w_nbeats;
    logic [c_BW-1:0]  w_hdr_word;
    logic [c_NBW-1:0] w_sel;
    logic [c_BW-1:0]  w_beat_word;
    logic             w_last_next;

    // Pruning-stage mask is MSB-first; the header mask is lane-indexed.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            w_mask[i] = in_dense | in_nonz[P-1-i];
        end
    end

    zc_compact #(
        .P  (P),
        .CW (CW)
    ) u_compact (
        .lane_data   (in_data),
        .lane_mask   (w_mask),
        .packed_data (w_packed),
        .nnz         (w_nnz)
    );

    always_comb begin
        w_nbeats   = c_NBW'((int'(w_nnz) + B - 1) / B);
        w_hdr_word = '0;
        w_hdr_word[HDR_MASK_LSB +: P] = w_mask;
        w_hdr_word[c_CNT_LSB +: CW]   = w_nnz;
    end

    // Selects the beat that becomes visible after the current handshake.
    always_comb begin
        w_sel       = (r_state == HDR) ? '0 : r_beat_cnt + c_NBW'(1);
        w_beat_word = '0;
        for (int j = 0; j < c_NBEAT; j++) begin
            if (w_sel == c_NBW'(j)) w_beat_word = r_packed[j*c_BW +: c_BW];
        end
        w_last_next = (w_sel == r_nbeats - c_NBW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_packed    <= '0;
            r_nbeats    <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_hdr   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_packed    <= w_packed;
                        r_nbeats    <= w_nbeats;
                        r_beat_cnt  <= '0;
                        r_out_valid <= 1'b1;
                        r_out_hdr   <= 1'b1;
                        r_out_last  <= (w_nbeats == '0);
                        r_out_data  <= w_hdr_word;
                        r_in_ready  <= 1'b0;
                        r_state     <= HDR;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        if (r_nbeats != '0) begin
                            r_out_hdr  <= 1'b0;
                            r_out_data <= w_beat_word;
                            r_out_last <= w_last_next;
                            r_state    <= DATA;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_hdr   <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_in_ready  <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (out_ready) begin
                        if (r_beat_cnt == r_nbeats - c_NBW'(1)) begin
                            r_beat_cnt  <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_in_ready  <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_beat_cnt <= w_sel;
                            r_out_data <= w_beat_word;
                            r_out_last <= w_last_next;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_hdr   = r_out_hdr;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_vpu_zc_packer.sv
// ============================================================================
// Module : tb_vpu_zc_packer
// Brief  : Self-checking bench: vector table, corner sequences, random traffic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vpu_zc_packer;

    localparam int P  = 64;
    localparam int B  = 16;
    localparam int CW = 7;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [P*8-1:0] in_data;
    logic [P-1:0]   in_nonz;
    logic           in_dense;
    logic           out_valid;
    logic           out_ready;
    logic [B*8-1:0] out_data;
    logic           out_hdr;
    logic           out_last;

    vpu_zc_packer #(.P(P), .B(B), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_nonz   (in_nonz),
        .in_dense  (in_dense),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_hdr   (out_hdr),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [P*8-1:0] data;
        logic [P-1:0]   nonz;
        logic           dense;
        logic [P-1:0]   exp_mask;
        int             exp_cnt;
        int             exp_nbeats;
    } vec_t;

    vec_t             tab[6];
    logic [B*8+1:0]   exp_q[$];
    logic [B*8-1:0]   last_hdr;
    int               beats_seen;
    int               n_tests;
    int               n_fail;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: gather masked-in bytes in lane order, then slice into beats.
    task automatic model(input logic [P*8-1:0] d, input logic [P-1:0] nz, input logic dn);
        logic [7:0]     bytes[$];
        logic [B*8-1:0] w;
        logic [P-1:0]   m;
        int             nb;
        exp_q.delete();
        m = '0;
        for (int i = 0; i < P; i++) begin
            if (dn || nz[P-1-i]) begin
                m[i] = 1'b1;
                bytes.push_back(d[8*i +: 8]);
            end
        end
        w = '0;
        w[P-1:0]  = m;
        w[P +: CW] = CW'(bytes.size());
        nb = (bytes.size() + B - 1) / B;
        exp_q.push_back({1'b1, (nb == 0), w});
        for (int j = 0; j < nb; j++) begin
            w = '0;
            for (int k = 0; k < B; k++) begin
                if (j*B + k < bytes.size()) w[8*k +: 8] = bytes[j*B + k];
            end
            exp_q.push_back({1'b0, (j == nb - 1), w});
        end
    endtask

    function automatic logic [P*8-1:0] rand_data();
        logic [P*8-1:0] d;
        for (int w = 0; w < P*8/32; w++) d[32*w +: 32] = $urandom;
        return d;
    endfunction

    task automatic run_vec(input logic [P*8-1:0] d, input logic [P-1:0] nz, input logic dn,
                           input int stall_at, input int stall_len);
        int guard;
        model(d, nz, dn);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        in_data   = d;
        in_nonz   = nz;
        in_dense  = dn;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand_data();
        in_nonz  = {$urandom, $urandom};
        in_dense = 1'b0;
        last_hdr   = '1;
        beats_seen = 0;
        for (int b = 0; b < exp_q.size(); b++) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_hdr", out_hdr, exp_q[b][B*8+1]);
            chk("beat_last", out_last, exp_q[b][B*8]);
            chk("beat_data", out_data, exp_q[b][B*8-1:0]);
            if (out_hdr) last_hdr = out_data;
            else beats_seen++;
            if (b == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); #1;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, exp_q[b][B*8-1:0]);
                    chk("stall_last", out_last, exp_q[b][B*8]);
                    chk("stall_hdr", out_hdr, exp_q[b][B*8+1]);
                    chk("stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("after_valid", out_valid, 0);
        chk("after_in_ready", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [P*8-1:0] seq;
        logic [P*8-1:0] sp;
        logic [P*8-1:0] d;
        logic [P-1:0]   nz;
        int             mode;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < P; i++) seq[8*i +: 8] = 8'(i + 1);
        sp = '0;
        sp[8*3 +: 8]  = 8'h11;
        sp[8*17 +: 8] = 8'h22;
        sp[8*63 +: 8] = 8'h33;

        tab[0] = '{seq, '1, 1'b0, '1, 64, 4};
        tab[1] = '{rand_data(), '0, 1'b0, '0, 0, 0};
        tab[2] = '{sp, 64'h1000_4000_0000_0001, 1'b0, 64'h8000_0000_0002_0008, 3, 1};
        tab[3] = '{seq, 64'hFFFF_8000_0000_0000, 1'b0, 64'h0000_0000_0001_FFFF, 17, 2};
        tab[4] = '{seq, 64'hFFFF_0000_0000_0000, 1'b0, 64'h0000_0000_0000_FFFF, 16, 1};
        tab[5] = '{rand_data(), 64'h0123_4567_89AB_CDEF, 1'b1, '1, 64, 4};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_nonz = '0; in_dense = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_valid", out_valid, 0);
        chk("reset_hdr", out_hdr, 0);
        chk("reset_last", out_last, 0);
        chk("reset_data", out_data, 0);
        chk("reset_in_ready", in_ready, 1);

        for (int t = 0; t < 6; t++) begin
            run_vec(tab[t].data, tab[t].nonz, tab[t].dense, -1, 0);
            chk("tab_mask", last_hdr[P-1:0], tab[t].exp_mask);
            chk("tab_cnt", last_hdr[P +: CW], tab[t].exp_cnt);
            chk("tab_hdr_pad", last_hdr[B*8-1:P+CW], 0);
            chk("tab_nbeats", beats_seen, tab[t].exp_nbeats);
        end

        // Hold data beat 2 of the all-ones vector for 5 cycles.
        run_vec(seq, '1, 1'b0, 2, 5);

        // Drop a packet with rst while data beat 1 is on the bus.
        in_data = seq; in_nonz = '1; in_dense = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_seq_hdr", out_hdr, 1);
        @(posedge clk); #1;
        chk("rst_seq_beat1", out_hdr == 1'b0 && out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_data", out_data, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_no_beats", out_valid, 0);
        end
        run_vec(sp, 64'h1000_4000_0000_0001, 1'b0, -1, 0);
        chk("rst_new_mask", last_hdr[P-1:0], 64'h8000_0000_0002_0008);

        for (int r = 0; r < 40; r++) begin
            d = rand_data();
            mode = $urandom_range(0, 3);
            case (mode)
                0: nz = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                1: nz = {$urandom, $urandom};
                2: nz = {$urandom, $urandom} | {$urandom, $urandom};
                default: nz = ~(64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(0, 64));
            endcase
            run_vec(d, nz, ($urandom_range(0, 7) == 0), $urandom_range(0, 5), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vpu_zc_packer.md
Name: vpu_zc_packer

Overview:
- Downstream of the vector processing unit (VPU): takes one P-lane 8-bit result vector plus its per-lane non-zero mask and emits a zero-compressed stream of B-byte beats toward the activation write-back buffer.
- Each vector becomes one header beat (lane mask + non-zero count), followed by ceil(nnz/B) data beats.
- Data beats carry only the masked-in bytes, packed in ascending lane order.
- A dense mode emits every byte uncompressed, for layers whose consumer needs dense data.

Parameters:
- P, 64, lanes per vector. P % B == 0 is required.
- B, 16, bytes per output beat. B*8 >= P + CW is required.
- CW, $clog2(P+1), width of the non-zero count field (7 at default).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, vector presented.
- in_ready, output, 1, vector accepted when in_valid && in_ready.
- in_data, input, P*8, lane i = in_data[8i+7:8i].
- in_nonz, input, P, non-zero mask from the pruning stage. Bit P-1-i belongs to lane i.
- in_dense, input, 1, 1 = emit all lanes uncompressed. Sampled at acceptance.
- out_valid, output, 1, beat available.
- out_ready, input, 1, consumer accepts beat.
- out_data, output, B*8, beat payload.
- out_hdr, output, 1, current beat is the header.
- out_last, output, 1, final beat of this vector.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; out_valid=0, out_hdr=0, out_last=0, out_data=0, in_ready=1 in the following cycle. Internal counters are 0.
- Reset mid-packet: the packet is discarded and no further beats appear. rst has priority over every other event.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid, capture and go to HDR.
  - HDR: out_valid=1, out_hdr=1. On out_ready: go to DATA if nbeats>0; else go to IDLE (out_last was 1).
  - DATA: out_valid=1, out_hdr=0. On out_ready: beat_cnt++. If beat_cnt==nbeats-1, go to IDLE.
- in_ready=1 only in IDLE. There is no back-to-back overlap: single-entry buffer, minimum 2 cycles per vector.
- Capture (acceptance edge):
  - lane_mask[i] = in_dense ? 1 : in_nonz[P-1-i].
  - nnz = popcount(lane_mask).
  - packed = compacted bytes: byte k = k-th set lane's data; bytes >= nnz are 0.
  - nbeats = ceil(nnz/B), computed as (nnz+B-1)/B.
  - Masked-in lanes are packed even if their value is 0. Masked-out lanes are dropped even if their value is non-zero.
- Header beat:
  - out_data[P-1:0] = lane_mask, with bit i = lane i.
  - out_data[P+CW-1:P] = nnz.
  - All remaining bits are 0.
  - out_last = (nbeats==0).
- Data beat j: out_data = packed bytes [j*B .. j*B+B-1], with byte 0 in bits [7:0]. Tail bytes are 0. out_last = (j==nbeats-1).
- Latency: header is valid the cycle after acceptance. Each subsequent beat follows one cycle after the previous handshake.
- Backpressure: while out_valid && !out_ready, all of out_data, out_hdr and out_last are held stable. out_valid never drops without a handshake, except on rst.
- Dense mode: nnz=P, nbeats=P/B, and the data is the original lane order.
- out_data is driven to 0 in IDLE.

Decomposition:
- Shared package vpu_pkg:
  - state enum {IDLE, HDR, DATA};
  - header field offsets HDR_MASK_LSB=0 and HDR_CNT_LSB=P;
  - function clog2.
- Sub-module zc_compact (combinational):
  - inputs: P-lane data and lane_mask; outputs: packed P bytes and nnz;
  - built from a prefix-popcount per lane plus a per-output-byte select;
  - its result is registered at capture in vpu_zc_packer.
- vpu_zc_packer holds the FSM, capture registers, beat counter and beat mux.

Test Plan:
- Dense-equivalent sparse: lane i = i+1, in_nonz all 1s, in_dense=0 -> header mask = 64'hFFFF_FFFF_FFFF_FFFF, cnt=64. Then 4 data beats with bytes 0x01..0x40 in order; out_last only on beat 4.
- Empty: in_nonz=0 -> single header beat with mask 0, cnt=0, out_last=1, out_hdr=1. in_ready=1 again the cycle after the handshake.
- Sparse: lanes 3, 17, 63 = 0x11, 0x22, 0x33; in_nonz bits 60, 46, 0 set -> header mask bits 3, 17, 63 set, cnt=3. Then one data beat with bytes[2:0] = 33,22,11 (byte0=0x11) and the rest 0, out_last=1.
- Boundary count: 17 non-zero lanes -> nbeats=2. Second beat has byte0 = 17th value and bytes 1..15 = 0; out_last on beat 2. Repeat with 16 lanes -> exactly 1 data beat.
- Backpressure: hold out_ready=0 for 5 cycles on data beat 2 of the all-ones case -> out_data/out_last stable and in_ready=0 throughout. Beat 3 appears one cycle after out_ready rises.
- Reset mid-packet: assert rst during data beat 1 -> next cycle out_valid=0, in_ready=1. A new sparse vector then produces a correct header, with no residue from the dropped packet.
